// File: rtl/bpsk_frame_extractor.sv
// BPSK frame extractor: after a preamble trigger, skips a fixed beat offset, decimates the I
// stream to one sample per symbol, hard-slices to bits and emits fixed-length AXIS byte frames.
module bpsk_frame_extractor #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLE_WIDTH           = 16,
  parameter int SAMPLES_PER_SYMBOL     = 16,
  parameter int START_OFFSET           = 8,
  parameter int PAYLOAD_BYTES          = 64
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  input  logic                                trigger,
  output logic                                m00_axis_tvalid,
  output logic [7:0]                          m00_axis_tdata,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic                                frame_active,
  output logic                                overflow,
  output logic [15:0]                         frame_count
);

  localparam int PhW  = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int SkW  = (START_OFFSET > 1) ? $clog2(START_OFFSET) : 1;
  localparam int IdxW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  typedef enum logic [1:0] {StIdle, StSkip, StCollect} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [SkW-1:0]  r_skip_cnt;
  logic [PhW-1:0]  r_phase;
  logic [2:0]      r_bit_cnt;
  logic [IdxW-1:0] r_byte_idx;
  logic [7:0]      r_shift;
  logic            r_m_tvalid;
  logic [7:0]      r_m_tdata;
  logic            r_m_tlast;
  logic            r_overflow;
  logic [15:0]     r_frame_count;

  logic       w_start;
  logic       w_sample;
  logic       w_bit;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_last_byte;
  logic       w_out_free;

  // Only the I sign bit is consumed; the rest of the beat is deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};

  assign s00_axis_tready = 1'b1;
  assign m00_axis_tvalid = r_m_tvalid;
  assign m00_axis_tdata  = r_m_tdata;
  assign m00_axis_tlast  = r_m_tlast;
  assign overflow        = r_overflow;
  assign frame_count     = r_frame_count;
  assign frame_active    = (r_state != StIdle);

  always_comb begin
    w_start     = (r_state == StIdle) && trigger;
    w_sample    = (r_state == StCollect) && s00_axis_tvalid && (r_phase == '0);
    w_bit       = ~s00_axis_tdata[SAMPLE_WIDTH-1];
    // Shift right so the earliest symbol ends up in bit 0.
    w_byte      = {w_bit, r_shift[7:1]};
    w_byte_done = w_sample && (r_bit_cnt == 3'd7);
    w_last_byte = (int'(r_byte_idx) == PAYLOAD_BYTES - 1);
    w_out_free  = !r_m_tvalid || m00_axis_tready;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (trigger) w_state_next = (START_OFFSET > 0) ? StSkip : StCollect;
      end
      StSkip: begin
        if (s00_axis_tvalid && (int'(r_skip_cnt) == START_OFFSET - 1)) w_state_next = StCollect;
      end
      StCollect: begin
        if (w_byte_done && w_last_byte) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) r_state <= StIdle;
    else                   r_state <= w_state_next;
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_skip_cnt    <= '0;
      r_phase       <= '0;
      r_bit_cnt     <= '0;
      r_byte_idx    <= '0;
      r_shift       <= '0;
      r_m_tvalid    <= 1'b0;
      r_m_tdata     <= '0;
      r_m_tlast     <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_start) begin
        r_frame_count <= r_frame_count + 16'd1;
        r_skip_cnt    <= '0;
        r_phase       <= '0;
        r_bit_cnt     <= '0;
        r_byte_idx    <= '0;
        r_shift       <= '0;
      end
      if ((r_state == StSkip) && s00_axis_tvalid) r_skip_cnt <= r_skip_cnt + 1'b1;
      if ((r_state == StCollect) && s00_axis_tvalid) begin
        r_phase <= (int'(r_phase) == SAMPLES_PER_SYMBOL - 1) ? '0 : r_phase + 1'b1;
      end
      if (w_sample) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_byte_done) begin
        r_byte_idx <= w_last_byte ? '0 : r_byte_idx + 1'b1;
        if (w_out_free) begin
          r_m_tvalid <= 1'b1;
          r_m_tdata  <= w_byte;
          r_m_tlast  <= w_last_byte;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (m00_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_frame_extractor.sv
// Scoreboard bench for bpsk_frame_extractor: randomized symbol streams, expected bytes queued
// from the frame payload, popped and compared by an independent output monitor.
module tb_bpsk_frame_extractor;

  localparam int SPS = 4;
  localparam int OFF = 2;

  logic        clk;
  logic        rst_n;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [3:0]  s_tstrb;
  logic        s_tready;
  logic        trig;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic        active;
  logic        ovf;
  logic [15:0] fcount;

  int          total;
  int          bad;
  int          exp_fc;
  logic        rand_ready;
  logic [8:0]  exp_q[$];

  bpsk_frame_extractor #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .SAMPLE_WIDTH          (16),
    .SAMPLES_PER_SYMBOL    (SPS),
    .START_OFFSET          (OFF),
    .PAYLOAD_BYTES         (2)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tready (s_tready),
    .trigger         (trig),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .frame_active    (active),
    .overflow        (ovf),
    .frame_count     (fcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Symbol sample for a bit: non-negative -> 1, negative -> 0, including the 0 / -1 edges.
  function automatic logic [31:0] sym(input logic b);
    logic [15:0] hi;
    logic [15:0] s;
    int          r;
    hi = 16'($urandom);
    r  = $urandom_range(0, 9);
    if (b) s = (r == 0) ? 16'h0000 : (r == 1) ? 16'h7fff : 16'($urandom_range(1, 32767));
    else   s = (r == 0) ? 16'h8000 : (r == 1) ? 16'hffff : -16'($urandom_range(1, 32767));
    return {hi, s};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic t);
    s_tvalid = v;
    s_tdata  = d;
    trig     = t;
    s_tlast  = 1'($urandom);
    s_tstrb  = 4'($urandom);
    if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'($urandom), $urandom, 1'b0);
  endtask

  // gap: 0 none, 1 one idle cycle before every valid beat, 2 random 0..2 idle cycles.
  task automatic vbeat(input int gap, input logic [31:0] d, input logic t);
    int g;
    g = (gap == 1) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < g; i++) drive(1'b0, $urandom, 1'b0);
    drive(1'b1, d, t);
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b1, b1});
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                           input int trig_at, input int nbits, input int tail);
    logic [15:0] bits;
    int          n;
    int          lim;
    bits = {b1, b0};
    n    = 0;
    drive(1'b1, $urandom, 1'b1);
    exp_fc++;
    check("active_after_trigger", 32'(active), 32'd1);
    for (int i = 0; i < OFF; i++) vbeat(gap, $urandom, 1'b0);
    for (int k = 0; k < nbits; k++) begin
      lim = (k == 15) ? 1 : SPS;
      for (int s = 0; s < lim; s++) begin
        vbeat(gap, (s == 0) ? sym(bits[k]) : $urandom, n == trig_at);
        n++;
      end
    end
    if (nbits == 16) begin
      check("active_after_frame", 32'(active), 32'd0);
      for (int i = 0; i < tail; i++) vbeat(gap, $urandom, 1'b0);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks hold stability.
  initial begin
    logic       held;
    logic [8:0] held_val;
    logic [8:0] e;
    held     = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_tvalid", 32'(m_tvalid), 32'd1);
          check("hold_data", 32'({m_tlast, m_tdata}), 32'(held_val));
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'({m_tlast, m_tdata}), 32'h1ff);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'({m_tlast, m_tdata}), 32'(e));
          end
        end
        held     = m_tvalid && !m_tready;
        held_val = {m_tlast, m_tdata};
      end
    end
  end

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;
    total = 0; bad = 0; exp_fc = 0; rand_ready = 1'b0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tstrb = '0;
    trig = 1'b0; m_tready = 1'b1;
    #3;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    check("rst_frame_count", 32'(fcount), 32'd0);
    check("s_tready_tied", 32'(s_tready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    push_frame(8'hA5, 8'h3C);
    run_frame(8'hA5, 8'h3C, 0, -1, 16, SPS - 1);
    idle(4);
    check("basic_frame_count", 32'(fcount), 32'(exp_fc));
    check("basic_overflow", 32'(ovf), 32'd0);

    push_frame(8'hA5, 8'h3C);
    run_frame(8'hA5, 8'h3C, 1, -1, 16, SPS - 1);
    idle(4);
    check("gapped_frame_count", 32'(fcount), 32'(exp_fc));

    push_frame(8'hA5, 8'h3C);
    run_frame(8'hA5, 8'h3C, 0, 10, 16, 0);
    idle(4);
    check("midtrig_frame_count", 32'(fcount), 32'(exp_fc));

    push_frame(8'h5A, 8'hC3);
    run_frame(8'h5A, 8'hC3, 0, -1, 16, 0);
    push_frame(8'h01, 8'h80);
    run_frame(8'h01, 8'h80, 0, -1, 16, 2);
    idle(4);
    check("b2b_frame_count", 32'(fcount), 32'(exp_fc));

    rand_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      push_frame(b0, b1);
      run_frame(b0, b1, $urandom_range(0, 2), -1, 16, $urandom_range(0, SPS - 1));
      idle($urandom_range(0, 5));
    end
    rand_ready = 1'b0;
    m_tready   = 1'b1;
    idle(6);
    check("random_frame_count", 32'(fcount), 32'(exp_fc));
    check("random_overflow", 32'(ovf), 32'd0);

    m_tready = 1'b0;
    exp_q.push_back({1'b0, 8'hA5});
    run_frame(8'hA5, 8'h3C, 0, -1, 16, 0);
    idle(3);
    check("bp_tvalid", 32'(m_tvalid), 32'd1);
    check("bp_tdata", 32'(m_tdata), 32'hA5);
    check("bp_tlast", 32'(m_tlast), 32'd0);
    check("bp_overflow", 32'(ovf), 32'd1);
    check("bp_active", 32'(active), 32'd0);
    m_tready = 1'b1;
    idle(3);
    check("bp_drained_tvalid", 32'(m_tvalid), 32'd0);
    check("bp_overflow_sticky", 32'(ovf), 32'd1);

    m_tready = 1'b0;
    run_frame(8'($urandom), 8'($urandom), 0, -1, 13, 0);
    check("pre_reset_tvalid", 32'(m_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_tdata", 32'(m_tdata), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_overflow", 32'(ovf), 32'd0);
    check("midrst_frame_count", 32'(fcount), 32'd0);
    exp_fc = 0;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    idle(2);
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    push_frame(b0, b1);
    run_frame(b0, b1, 2, -1, 16, 1);
    idle(4);
    check("fresh_frame_count", 32'(fcount), 32'(exp_fc));
    check("fresh_overflow", 32'(ovf), 32'd0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
